// File: rtl/circuit_pkg.sv
// Shared constants and types for the programmable 4-input LUT cell.
package circuit_pkg;

    localparam int IDX_W = 4;
    localparam int TT_W  = 16;

    typedef logic [TT_W-1:0] tt_t;

    // f = (a ^ b) | (c & d), with bit i holding f for index {a,b,c,d} = i
    localparam tt_t DEFAULT_TT = 16'h8FF8;

endpackage : circuit_pkg

// File: rtl/circuit_lut4.sv
// Combinational 16:1 LUT mux with a one-hot decode of the selecting index.
module circuit_lut4
    import circuit_pkg::*;
(
    input  tt_t              tt,
    input  logic [IDX_W-1:0] idx,
    output logic             f,
    output logic [TT_W-1:0]  minterm
);

    // One decoder line per table entry
    generate
        for (genvar gi = 0; gi < TT_W; gi++) begin : g_minterm
            assign minterm[gi] = (idx == IDX_W'(gi));
        end
    endgenerate

    // Table lookup: the selected bit is the function value
    always_comb begin
        f = tt[idx];
    end

endmodule : circuit_lut4

// File: rtl/circuit.sv
// Programmable 4-input Boolean function cell (a,b,c,d -> f).
// Holds the rewritable truth table, a registered copy of f and, when
// CIRCUIT_HIT_COUNT_EN is defined, a saturating count of cycles with f_q = 1.
// A table write is visible from the cycle after cfg_we is sampled.
module circuit
    import circuit_pkg::*;
#(
    parameter tt_t TRUTH_TABLE = DEFAULT_TT,
    parameter int  CNT_W       = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             f,
    output logic             f_q,
    output logic [TT_W-1:0]  minterm,
    input  logic             cfg_we,
    input  tt_t              cfg_data,
`ifdef CIRCUIT_HIT_COUNT_EN
    output logic [CNT_W-1:0] hit_cnt,
`endif
    output tt_t              tt
);

    logic [IDX_W-1:0] idx;
    tt_t              tt_q;
    tt_t              tt_d;
    logic             f_d;

    assign idx = {a, b, c, d};
    assign tt  = tt_q;

    circuit_lut4 u_lut4 (
        .tt      (tt_q),
        .idx     (idx),
        .f       (f),
        .minterm (minterm)
    );

    // Next table: a write replaces the whole table, otherwise hold
    always_comb begin
        tt_d = tt_q;
        if (cfg_we) begin
            tt_d = cfg_data;
        end
        f_d = f;
    end

    // Table and registered output; reset wins over a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q <= TRUTH_TABLE;
            f_q  <= 1'b0;
        end else begin
            tt_q <= tt_d;
            f_q  <= f_d;
        end
    end

`ifdef CIRCUIT_HIT_COUNT_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] hit_cnt_d;

    assign hit_cnt = hit_cnt_q;

    // Count cycles with f_q high, sticking at all-ones; a table write restarts it
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (cfg_we) begin
            hit_cnt_d = '0;
        end else if (f_q && !(&hit_cnt_q)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    // Hit counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end
`endif

endmodule : circuit

// File: tb/tb_circuit.sv
// Self-checking bench for circuit: directed test-plan items plus randomized
// cycles compared against a behavioural model of the table, f_q and counter.
module tb_circuit;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk;
    logic        rst;
    logic        a, b, c, d;
    logic        f;
    logic        f_q;
    logic [15:0] minterm;
    logic        cfg_we;
    logic [15:0] cfg_data;
    logic [15:0] tt;
`ifdef CIRCUIT_HIT_COUNT_EN
    logic [CNT_W-1:0] hit_cnt;
`endif

    circuit #(.TRUTH_TABLE(16'h8FF8), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .f        (f),
        .f_q      (f_q),
        .minterm  (minterm),
        .cfg_we   (cfg_we),
        .cfg_data (cfg_data),
`ifdef CIRCUIT_HIT_COUNT_EN
        .hit_cnt  (hit_cnt),
`endif
        .tt       (tt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    logic [15:0] m_tt;
    logic        m_fq;
    int          m_cnt;
    logic        last_f;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, clock, check state
    task automatic step(input logic [3:0] idx, input logic we, input logic [15:0] data,
                        input logic r, input string tag);
        logic        f_exp;
        logic [15:0] mt_exp;
        logic        fq_old;
        {a, b, c, d} = idx;
        cfg_we   = we;
        cfg_data = data;
        rst      = r;
        #1;
        f_exp  = m_tt[idx];
        mt_exp = 16'd0;
        mt_exp[idx] = 1'b1;
        last_f = f;
        check_eq({tag, ":f"}, {31'd0, f}, {31'd0, f_exp});
        check_eq({tag, ":minterm"}, {16'd0, minterm}, {16'd0, mt_exp});
        @(posedge clk);
        fq_old = m_fq;
        if (r) begin
            m_tt  = 16'h8FF8;
            m_fq  = 1'b0;
            m_cnt = 0;
        end else begin
            m_fq = f_exp;
            if (we) begin
                m_tt  = data;
                m_cnt = 0;
            end else if (fq_old && m_cnt < CNT_MAX) begin
                m_cnt = m_cnt + 1;
            end
        end
        #1;
        check_eq({tag, ":f_q"}, {31'd0, f_q}, {31'd0, m_fq});
        check_eq({tag, ":tt"}, {16'd0, tt}, {16'd0, m_tt});
`ifdef CIRCUIT_HIT_COUNT_EN
        check_eq({tag, ":hit_cnt"}, 32'(hit_cnt), 32'(m_cnt));
`endif
        $display("[TB] %s idx=%0d we=%0b rst=%0b f=%0b f_q=%0b tt=%04h", tag, idx, we, r, last_f, f_q, tt);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_data = 16'h0; {a, b, c, d} = 4'd0;
        m_tt = 16'hxxxx; m_fq = 1'b0; m_cnt = 0;
        @(negedge clk);
        m_tt = 16'h8FF8;
        step(4'd0, 1'b0, 16'h0, 1'b1, "reset");
        check_eq("reset_tt", {16'd0, tt}, 32'h8FF8);
        check_eq("reset_fq", {31'd0, f_q}, 32'd0);

        // Sweep all indices against the default Boolean function
        for (int i = 0; i < 16; i++) begin
            logic [3:0] iv;
            logic       fb;
            iv = 4'(i);
            step(iv, 1'b0, 16'h0, 1'b0, "sweep");
            fb = (iv[3] ^ iv[2]) | (iv[1] & iv[0]);
            check_eq("sweep_formula", {31'd0, last_f}, {31'd0, fb});
        end

        // f_q follows f with one cycle of latency
        step(4'b0101, 1'b0, 16'h0, 1'b0, "hold5");
        check_eq("hold5_fq", {31'd0, f_q}, 32'd1);
        step(4'b0000, 1'b0, 16'h0, 1'b0, "hold0");
        check_eq("hold0_fq", {31'd0, f_q}, 32'd0);

        // Table write: old table used in the write cycle
        step(4'b1111, 1'b1, 16'h8000, 1'b0, "write");
        check_eq("write_old_f", {31'd0, last_f}, 32'd1);
        check_eq("write_tt", {16'd0, tt}, 32'h8000);
        step(4'd4, 1'b0, 16'h0, 1'b0, "after_wr");
        check_eq("after_wr_idx4", {31'd0, last_f}, 32'd0);
        step(4'd15, 1'b0, 16'h0, 1'b0, "after_wr15");
        check_eq("after_wr_idx15", {31'd0, last_f}, 32'd1);

        // Reset beats a simultaneous write
        step(4'd4, 1'b1, 16'h0000, 1'b1, "rst_we");
        check_eq("rst_we_tt", {16'd0, tt}, 32'h8FF8);
        step(4'd4, 1'b0, 16'h0, 1'b0, "rst_we_f");
        check_eq("rst_we_idx4", {31'd0, last_f}, 32'd1);

        // Randomized traffic: occasional writes and rare resets
        for (int n = 0; n < 400; n++) begin
            logic we_r, rst_r;
            we_r  = ($urandom_range(0, 9) == 0);
            rst_r = ($urandom_range(0, 49) == 0);
            step(4'($urandom_range(0, 15)), we_r, 16'($urandom), rst_r, "rand");
        end

`ifdef CIRCUIT_HIT_COUNT_EN
        // Saturation of the hit counter, then clear by a write
        step(4'd0, 1'b0, 16'h0, 1'b1, "cnt_rst");
        for (int n = 0; n < 300; n++) begin
            step(4'd3, 1'b0, 16'h0, 1'b0, "cnt_hold");
        end
        check_eq("cnt_sat", 32'(hit_cnt), 32'(CNT_MAX));
        step(4'd3, 1'b1, 16'h8FF8, 1'b0, "cnt_clr");
        check_eq("cnt_clr", 32'(hit_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_circuit
